// File: rtl/chaos_ks_pkg.sv
// Shared types for the chaotic-map keystream scheduler: FSM states and the
// per-iteration byte index.
package chaos_ks_pkg;

   localparam int BYTES_PER_ITER = 3;
   localparam int IDX_W          = $clog2(BYTES_PER_ITER);

   typedef logic [IDX_W-1:0] byte_idx_t;

   localparam byte_idx_t LAST_IDX = byte_idx_t'(BYTES_PER_ITER - 1);

   typedef enum logic [2:0] {
      IDLE,
      STEP,
      WAIT,
      EXTRACT,
      LATCH,
      EMIT
   } ks_state_t;

endpackage

// File: rtl/ks_byte_serializer.sv
// Serialises the low bytes of the three extractor mantissas into a byte
// stream; the index advances on each accepted byte and wraps after the last.
module ks_byte_serializer
   import chaos_ks_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        advance,
   input  logic [22:0] ex1,
   input  logic [22:0] ex2,
   input  logic [22:0] ex3,
   output logic [7:0]  byte_data,
   output logic        last_byte
);

   byte_idx_t idx;

   assign last_byte = (idx == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         idx <= '0;
      else if (clear)
         idx <= '0;
      else if (advance)
         idx <= last_byte ? '0 : byte_idx_t'(idx + 1'b1);
   end

   always_comb begin
      byte_data = ex1[7:0];
      case (idx)
         byte_idx_t'(1): byte_data = ex2[7:0];
         byte_idx_t'(2): byte_data = ex3[7:0];
         default:        byte_data = ex1[7:0];
      endcase
   end

   // Only the low byte of each mantissa feeds the keystream.
   logic unused_ex_hi;
   assign unused_ex_hi = ^{ex1[22:8], ex2[22:8], ex3[22:8]};

endmodule

// File: rtl/keystream_scheduler.sv
// Sequences chaotic-map iterations, mantissa extraction and byte emission.
// Optional warm-up discard is built only when KS_WARMUP_EN is defined.
module keystream_scheduler
   import chaos_ks_pkg::*;
#(
   parameter int WARMUP_ITERS = 16,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   output logic             map_start,
   input  logic             map_done,
   output logic             enable_extract,
   input  logic [22:0]      ex1,
   input  logic [22:0]      ex2,
   input  logic [22:0]      ex3,
   output logic [7:0]       ks_data,
   output logic             ks_valid,
   input  logic             ks_ready,
   output logic             busy,
   output logic [CNT_W-1:0] iter_count
);

   ks_state_t  state, state_nxt;
   logic       start_ok, xfer, last_byte, iter_done, warm_left;
   logic [7:0] byte_data;

   assign start_ok  = (state == IDLE) && start && !stop;
   assign xfer      = (state == EMIT) && ks_ready;
   assign iter_done = xfer && last_byte && !stop;

`ifdef KS_WARMUP_EN
   logic [CNT_W-1:0] warmup;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         warmup <= '0;
      else if (start_ok)
         warmup <= CNT_W'(WARMUP_ITERS);
      else if (state == WAIT && map_done && !stop && warm_left)
         warmup <= warmup - 1'b1;
   end

   assign warm_left = (warmup != '0);
`else
   assign warm_left = 1'b0;

   logic unused_warmup_iters;
   assign unused_warmup_iters = ^WARMUP_ITERS;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      map_start      = 1'b0;
      enable_extract = 1'b0;
      ks_valid       = 1'b0;
      ks_data        = '0;
      busy           = (state != IDLE);
      case (state)
         IDLE:    if (start) state_nxt = STEP;
         STEP:    begin
                     map_start = 1'b1;
                     state_nxt = WAIT;
                  end
         WAIT:    if (map_done) state_nxt = warm_left ? STEP : EXTRACT;
         EXTRACT: begin
                     enable_extract = 1'b1;
                     state_nxt      = LATCH;
                  end
         LATCH:   state_nxt = EMIT;
         EMIT:    begin
                     ks_valid = 1'b1;
                     ks_data  = byte_data;
                     if (xfer && last_byte) state_nxt = STEP;
                  end
         default: state_nxt = IDLE;
      endcase
      // Abort wins over every other transition, including start and map_done.
      if (stop) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         iter_count <= '0;
      else if (start_ok)
         iter_count <= '0;
      else if (iter_done)
         iter_count <= iter_count + 1'b1;
   end

   ks_byte_serializer u_ser (
      .clk       (clk),
      .rst       (rst),
      .clear     (stop || (state != EMIT)),
      .advance   (xfer),
      .ex1       (ex1),
      .ex2       (ex2),
      .ex3       (ex3),
      .byte_data (byte_data),
      .last_byte (last_byte)
   );

endmodule

// File: tb/tb_keystream_scheduler.sv
// Bench for keystream_scheduler: directed handshake/latency/abort steps, then
// randomized map latency and consumer backpressure against a byte queue model.
module tb_keystream_scheduler;

   localparam int CNT_W = 16;
`ifdef KS_WARMUP_EN
   localparam int WU = 4;
`else
   localparam int WU = 0;
`endif

   logic             clk = 1'b0;
   logic             rst, start, stop, map_done, ks_ready;
   logic             map_start, enable_extract, ks_valid, busy;
   logic [22:0]      ex1, ex2, ex3;
   logic [7:0]       ks_data;
   logic [CNT_W-1:0] iter_count;

   logic             auto_mode, man_done, auto_done, fixed_mode, pend;
   int unsigned      dly;
   logic [22:0]      r1, r2, r3;
   logic [7:0]       exp_q[$];
   int               checks = 0;
   int               errors = 0;

   always #5 clk = ~clk;

   assign map_done = auto_mode ? auto_done : man_done;

   keystream_scheduler #(.WARMUP_ITERS(4), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .stop           (stop),
      .map_start      (map_start),
      .map_done       (map_done),
      .enable_extract (enable_extract),
      .ex1            (ex1),
      .ex2            (ex2),
      .ex3            (ex3),
      .ks_data        (ks_data),
      .ks_valid       (ks_valid),
      .ks_ready       (ks_ready),
      .busy           (busy),
      .iter_count     (iter_count)
   );

   // Map model: answers each map_start after 1..4 cycles.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         auto_done <= 1'b0;
         pend      <= 1'b0;
         dly       <= 0;
      end else begin
         auto_done <= 1'b0;
         if (map_start) begin
            pend <= 1'b1;
            dly  <= $urandom_range(0, 3);
         end else if (pend) begin
            if (dly == 0) begin
               auto_done <= 1'b1;
               pend      <= 1'b0;
            end else
               dly <= dly - 1;
         end
      end
   end

   always @(negedge clk) begin
      r1 <= 23'($urandom);
      r2 <= 23'($urandom);
      r3 <= 23'($urandom);
   end

   // Extractor model: registers new mantissas on enable_extract and records
   // the three bytes the consumer must see next.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ex1 <= '0;
         ex2 <= '0;
         ex3 <= '0;
      end else if (enable_extract) begin
         ex1 <= fixed_mode ? {r1[22:8], 8'h11} : r1;
         ex2 <= fixed_mode ? {r2[22:8], 8'h22} : r2;
         ex3 <= fixed_mode ? {r3[22:8], 8'h33} : r3;
         exp_q.push_back(fixed_mode ? 8'h11 : r1[7:0]);
         exp_q.push_back(fixed_mode ? 8'h22 : r2[7:0]);
         exp_q.push_back(fixed_mode ? 8'h33 : r3[7:0]);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // From a STEP cycle, answer `rounds` map requests by hand; ends in the
   // cycle right after the last map_done edge.
   task automatic go_extract(input int rounds, output int pulses);
      pulses = 0;
      for (int i = 0; i < rounds; i++) begin
         if (map_start) pulses++;
         chk("no_early_extract", enable_extract, 0);
         step();
         chk("wait_no_map_start", map_start, 0);
         man_done = 1'b1;
         step();
         man_done = 1'b0;
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_map_start"}, map_start, 0);
      chk({tag, "_enable_extract"}, enable_extract, 0);
      chk({tag, "_ks_valid"}, ks_valid, 0);
      chk({tag, "_ks_data"}, ks_data, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int p;
      int xfers;
      logic hold;
      logic [7:0] prev, eb;

      rst = 1'b1; start = 1'b0; stop = 1'b0; ks_ready = 1'b0;
      man_done = 1'b0; auto_mode = 1'b0; fixed_mode = 1'b1;
      step(); step();
      chk_idle_outputs("reset");
      chk("reset_iter_count", iter_count, 0);
      rst = 1'b0;
      step();

      // start and stop together in IDLE: nothing happens
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      chk("startstop_busy", busy, 0);
      chk("startstop_map_start", map_start, 0);
      step();
      chk("startstop_map_start2", map_start, 0);

      // first iteration with fixed bytes and latency checks
      ks_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_map_start", map_start, 1);
      chk("start_busy", busy, 1);
      go_extract(WU + 1, p);
      chk("first_extract", enable_extract, 1);
      chk("map_pulses_before_extract", p, WU + 1);
      chk("extract_no_valid", ks_valid, 0);
      step();
      chk("latch_no_extract", enable_extract, 0);
      chk("latch_no_valid", ks_valid, 0);
      step();
      chk("b0_valid", ks_valid, 1);
      chk("b0_data", ks_data, 8'h11);
      step();
      chk("b1_data", ks_data, 8'h22);
      step();
      chk("b2_data", ks_data, 8'h33);
      step();
      chk("next_map_start", map_start, 1);
      chk("after_b2_valid", ks_valid, 0);
      chk("iter_count_1", iter_count, 1);

      // backpressure on byte 1; start while busy must be ignored
      go_extract(1, p);
      chk("second_extract", enable_extract, 1);
      step(); step();
      chk("bp_b0_data", ks_data, 8'h11);
      step();
      chk("bp_b1_data", ks_data, 8'h22);
      ks_ready = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold_valid", ks_valid, 1);
         chk("bp_hold_data", ks_data, 8'h22);
      end
      start = 1'b0;
      ks_ready = 1'b1;
      step();
      chk("bp_b2_data", ks_data, 8'h33);
      step();
      chk("bp_next_map_start", map_start, 1);
      chk("iter_count_2", iter_count, 2);

      // stop in WAIT together with map_done, then a late map_done
      step();
      stop = 1'b1; man_done = 1'b1;
      step();
      stop = 1'b0; man_done = 1'b0;
      chk_idle_outputs("stop_wait");
      man_done = 1'b1;
      step();
      man_done = 1'b0;
      chk_idle_outputs("late_done");
      step();
      chk_idle_outputs("late_done2");

      // new session clears the count; reset during byte 1
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_iter_count", iter_count, 0);
      go_extract(WU + 1, p);
      chk("warmup_reload_pulses", p, WU + 1);
      step(); step();
      chk("rst_b0_data", ks_data, 8'h11);
      step();
      chk("rst_b1_data", ks_data, 8'h22);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", ks_valid, 0);
      chk("async_rst_busy", busy, 0);
      step();
      rst = 1'b0;
      chk_idle_outputs("after_rst");
      chk("after_rst_iter_count", iter_count, 0);
      man_done = 1'b1;
      step();
      man_done = 1'b0;
      chk_idle_outputs("rst_late_done");
      start = 1'b1;
      step();
      start = 1'b0;
      go_extract(WU + 1, p);
      step(); step(); step(); step();
      chk("post_rst_b2", ks_data, 8'h33);
      step();
      chk("post_rst_iter_count", iter_count, 1);

      // randomized map latency and consumer backpressure
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("pre_rand_busy", busy, 0);
      exp_q.delete();
      fixed_mode = 1'b0;
      auto_mode  = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      xfers = 0;
      hold  = 1'b0;
      prev  = '0;
      for (int c = 0; c < 800; c++) begin
         if (hold) begin
            chk("rand_hold_valid", ks_valid, 1);
            chk("rand_hold_data", ks_data, prev);
         end
         chk("rand_iter_count", iter_count, CNT_W'(xfers / 3));
         ks_ready = ($urandom_range(0, 3) != 0);
         if (ks_valid && ks_ready) begin
            chk("rand_queue_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               eb = exp_q.pop_front();
               chk("rand_byte", ks_data, eb);
            end
            xfers++;
         end
         hold = ks_valid && !ks_ready;
         prev = ks_data;
         step();
      end
      chk("rand_progress", xfers > 30, 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk_idle_outputs("final_stop");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keystream_scheduler.md
KEYSTREAM_SCHEDULER -- requirements
Module: keystream_scheduler

Interface
REQ-001 SHALL have parameter: WARMUP_ITERS, 16, number of chaotic-map iterations discarded after each start.
REQ-002 SHALL have parameter: CNT_W, 16, width of the iteration counters.
REQ-003 SHALL have port: clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: start  in  1  begins a keystream session; sampled in IDLE only.
REQ-006 SHALL have port: stop  in  1  aborts the session from any state.
REQ-007 SHALL have port: map_start  out  1  one-cycle pulse requesting one chaotic-map iteration.
REQ-008 SHALL have port: map_done  in  1  map iteration complete; map values valid.
REQ-009 SHALL have port: enable_extract  out  1  one-cycle pulse to the mantissa extractor.
REQ-010 SHALL have ports: ex1, ex2, ex3  in  23 each  registered mantissas from the extractor.
REQ-011 SHALL have port: ks_data  out  8  keystream byte.
REQ-012 SHALL have port: ks_valid  out  1  ks_data valid.
REQ-013 SHALL have port: ks_ready  in  1  consumer accepts the byte.
REQ-014 SHALL have ports: busy  out  1  state not IDLE; iter_count  out  CNT_W  emitted iterations this session.

Function
REQ-015 SHALL implement states IDLE, STEP, WAIT, EXTRACT, LATCH and EMIT.
REQ-016 IDLE: start=1 and stop=0 -> STEP; otherwise stay in IDLE.
REQ-017 STEP: map_start=1 for exactly this cycle -> WAIT.
REQ-018 WAIT: map_done is ignored in every other state. On map_done=1, if warmup remaining>0, decrement it -> STEP; else -> EXTRACT.
REQ-019 EXTRACT: enable_extract=1 for exactly this cycle -> LATCH.
REQ-020 LATCH: one cycle while the extractor registers update -> EMIT with byte index 0.
REQ-021 EMIT: byte index 0,1,2 -> ks_data = ex1[7:0], ex2[7:0], ex3[7:0]; ks_valid=1 throughout.
REQ-022 Handshake: a byte transfers when ks_valid&&ks_ready. ks_data is held stable while ks_valid&&!ks_ready. ks_valid never depends combinationally on ks_ready.
REQ-023 After byte 2 transfers: iter_count increments (wraps mod 2^CNT_W) -> STEP, with no idle cycle.
REQ-024 Latency: start sampled at edge k -> map_start high in cycle k+1. map_done sampled at edge m -> enable_extract in cycle m+1, ks_valid in cycle m+3.
REQ-025 stop=1 at any edge -> IDLE next cycle; ks_valid, map_start and enable_extract fall to 0; the byte index is cleared.
REQ-026 stop takes precedence over start and over map_done.
REQ-027 start while busy SHALL be ignored.
REQ-028 A new start SHALL clear iter_count and reload warmup remaining from WARMUP_ITERS.

Reset
REQ-029 rst SHALL force: state=IDLE, map_start=0, enable_extract=0, ks_valid=0, ks_data=0, busy=0, iter_count=0, warmup=0, byte index=0.
REQ-030 Reset mid-session SHALL take effect immediately and discard any in-flight byte; a late map_done after reset SHALL be ignored.

Configuration
REQ-031 Macro KS_WARMUP_EN SHALL control warm-up. Defined: the first WARMUP_ITERS map_done events per session are discarded (no enable_extract). WARMUP_ITERS=0 means no discard.
REQ-032 Undefined: no warm-up counter is built, WARMUP_ITERS is ignored, and the first map_done goes to EXTRACT.

Structure
REQ-033 Package chaos_ks_pkg SHALL hold the state enum, the BYTES_PER_ITER=3 constant and the byte-index type.
REQ-034 The byte selection mux plus index counter SHALL be sub-module ks_byte_serializer; the FSM stays in keystream_scheduler.

Verification
REQ-035 WARMUP off, ex1/2/3 low bytes 0x11/0x22/0x33, ks_ready=1 -> bytes 0x11,0x22,0x33 on consecutive cycles; iter_count=1; next map_start the following cycle.
REQ-036 KS_WARMUP_EN, WARMUP_ITERS=4 -> exactly 5 map_start pulses before the first enable_extract.
REQ-037 ks_ready low 5 cycles on byte 1 -> ks_data stays 0x22 with ks_valid=1 throughout; no byte lost or duplicated.
REQ-038 stop asserted in WAIT, then map_done -> IDLE, busy=0, no enable_extract, no ks_valid.
REQ-039 rst pulsed during EMIT byte 1 -> all outputs 0 next cycle. Then start -> iter_count restarts from 0.
REQ-040 start and stop asserted together in IDLE -> remain in IDLE with no map_start.
